uart_tx_fifo: RTL and testbench
===============================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, holding the number of byte entries in the transmit FIFO; the value is a power of 2 and at least 2.
REQ-002 SHALL have parameter STOP_BITS, default 1, holding the number of stop bits per frame; the legal values are 1 and 2.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port baud_tick, input, 1 bit: a one-cycle pulse at the bit rate, synchronous to clk.
REQ-006 SHALL have port data_in, input, 8 bits: the byte to enqueue.
REQ-007 SHALL have port tx_valid, input, 1 bit: data_in is valid.
REQ-008 SHALL have port tx_ready, output, 1 bit: the FIFO can accept a byte.
REQ-009 SHALL have port tx_serial, output, 1 bit: the serial line; it idles high.
REQ-010 SHALL have port tx_busy, output, 1 bit: a frame is in progress (any state other than IDLE).
REQ-011 SHALL have port tx_done, output, 1 bit: a one-cycle pulse when a frame completes.
REQ-012 SHALL have port fifo_count, output, $clog2(FIFO_DEPTH)+1 bits: the current FIFO occupancy.

Function
REQ-013 SHALL accept a byte on any clk edge where tx_valid and tx_ready are both 1; a byte is never dropped, and bytes are transmitted in acceptance order.
REQ-014 SHALL set tx_ready = (fifo_count != FIFO_DEPTH), derived from registered state only; when full, a push is refused even if a pop occurs in the same cycle.
REQ-015 SHALL, on a simultaneous accepted push and pop, leave fifo_count unchanged; the read and write pointers wrap modulo FIFO_DEPTH.
REQ-016 SHALL implement the FSM states IDLE, START, DATA, PARITY (present only when parity is compiled in) and STOP; every state transition occurs only on a cycle with baud_tick = 1.
REQ-017 SHALL, in IDLE with fifo_count > 0 (registered) and baud_tick = 1, pop the head byte into the shift register and enter START.
- A byte pushed into an empty FIFO therefore starts on the next qualifying tick, never on the same one.
REQ-018 SHALL drive tx_serial as follows, registered, from the cycle after the state entry: IDLE = 1, START = 0, DATA = shift-register bit 0, PARITY = parity bit, STOP = 1.
REQ-019 SHALL, in DATA, shift right on each baud_tick so the byte goes out LSB first, using a 3-bit bit index; after bit 7's tick it enters PARITY or STOP.
REQ-020 SHALL hold STOP for STOP_BITS baud_tick intervals.
REQ-021 SHALL, on the final STOP tick, pulse tx_done for exactly one cycle and then:
- if fifo_count > 0, pop and enter START directly (back-to-back frames with no idle bit);
- otherwise, enter IDLE.
REQ-022 SHALL hold tx_busy = 1 from START entry until IDLE re-entry; tx_busy stays 1 across back-to-back frames.
REQ-023 SHALL ignore baud_tick pulses for frame progress while in IDLE with an empty FIFO.
REQ-024 SHALL not alter the frame in flight when data_in or tx_valid change; frame data is taken only from the shift register.

Reset
REQ-025 SHALL, on the clk edge with rst = 1, apply these reset values:
- state = IDLE;
- tx_serial = 1, tx_busy = 0, tx_done = 0;
- FIFO pointers = 0, fifo_count = 0, tx_ready = 1 on the next cycle;
- bit index = 0, stop counter = 0.
REQ-026 SHALL, on reset during a frame, abort the frame and flush the FIFO; the line returns high on the cycle after the reset edge and no tx_done is generated.
REQ-027 SHALL refuse pushes during a cycle in which rst = 1.

Configuration
REQ-028 SHALL, when macro UART_TX_PARITY_EN is defined, include the PARITY state.
- The parity bit is the even-parity bit: XOR of the 8 data bits.
- It is sent for one baud interval between bit 7 and STOP.
- A frame is 11 bits (STOP_BITS = 1).
REQ-029 SHALL, when UART_TX_PARITY_EN is undefined, omit the PARITY state and parity logic entirely; DATA goes directly to STOP and a frame is 10 bits (STOP_BITS = 1).

Verification
REQ-030 SHALL cover, with STOP_BITS = 1 and no parity: push 0xA5 -> line samples per tick are 0,1,0,1,0,0,1,0,1,1; tx_done pulses once; tx_busy falls and the line stays 1.
REQ-031 SHALL cover, with UART_TX_PARITY_EN defined: push 0x07 -> data bits 1,1,1,0,0,0,0,0, then parity 1, then stop 1.
REQ-032 SHALL cover back-to-back transfer: push 0x55 and 0x0F consecutively -> 20 contiguous bit periods with no idle bit, two tx_done pulses, and tx_busy constantly 1.
REQ-033 SHALL cover full FIFO with FIFO_DEPTH = 4: with baud_tick held low, push 5 bytes -> tx_ready = 0 after the 4th, the 5th is refused and fifo_count = 4; then enable ticks -> only the 4 accepted bytes are transmitted, in order.
REQ-034 SHALL cover reset mid-frame: assert rst during DATA bit 3 with 2 bytes queued -> tx_serial = 1, fifo_count = 0 and tx_busy = 0 after one cycle, with no tx_done.
REQ-035 SHALL cover STOP_BITS = 2: push 0xFF -> start 0, eight 1s, then the line stays high for 2 tick periods before tx_done.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte-wide transmit FIFO feeding an 8N1/8E1-style UART serializer.
//
// Bytes offered with tx_valid are queued while tx_ready is high and are sent
// LSB first, framed by a start bit (0) and STOP_BITS stop bits (1). Frame
// progress advances only on baud_tick. When a frame ends and more bytes are
// queued, the next start bit follows immediately with no idle bit.
//
// Optional feature macro: UART_TX_PARITY_EN
//   When defined, an even-parity bit (XOR of the data bits) is sent between
//   data bit 7 and the stop bit(s).
//
// Parameters:
//   FIFO_DEPTH  number of byte entries (power of 2, >= 2)
//   STOP_BITS   stop bits per frame (1 or 2)
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   baud_tick   one-cycle pulse at the bit rate
//   data_in     byte to enqueue
//   tx_valid    data_in is valid
//   tx_ready    FIFO can accept a byte
//   tx_serial   serial line (idles high)
//   tx_busy     a frame is in progress
//   tx_done     one-cycle pulse when a frame completes
//   fifo_count  current FIFO occupancy
module uart_tx_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int STOP_BITS  = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          baud_tick,
  input  logic [7:0]                    data_in,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          tx_serial,
  output logic                          tx_busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t          state_q, state_d;
  logic [7:0]      fifo_mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [7:0]      shift_q, shift_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [1:0]      stop_cnt_q, stop_cnt_d;
  logic            tx_serial_q, tx_serial_d;
  logic            tx_done_q, tx_done_d;
  logic            push, pop;
`ifdef UART_TX_PARITY_EN
  logic            parity_q, parity_d;

  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction
`endif

  assign tx_ready   = (count_q != CW'(FIFO_DEPTH));
  assign tx_busy    = (state_q != IDLE);
  assign tx_serial  = tx_serial_q;
  assign tx_done    = tx_done_q;
  assign fifo_count = count_q;

  // A byte is refused while reset is asserted, and when full even if a pop
  // happens in the same cycle (tx_ready looks only at registered occupancy).
  assign push = tx_valid && tx_ready && !rst;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    stop_cnt_d = stop_cnt_q;
    tx_done_d  = 1'b0;
    pop        = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif
    if (baud_tick) begin
      case (state_q)
        IDLE: begin
          if (count_q != '0) begin
            pop     = 1'b1;
            state_d = START;
          end
        end
        START: begin
          state_d   = DATA;
          bit_idx_d = '0;
        end
        DATA: begin
          if (bit_idx_q == 3'd7) begin
            bit_idx_d  = '0;
            stop_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d    = PARITY;
`else
            state_d    = STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          state_d    = STOP;
          stop_cnt_d = '0;
        end
`endif
        STOP: begin
          if (stop_cnt_q == 2'(STOP_BITS - 1)) begin
            tx_done_d  = 1'b1;
            stop_cnt_d = '0;
            // Chain straight into the next frame when data is waiting.
            if (count_q != '0) begin
              pop     = 1'b1;
              state_d = START;
            end else begin
              state_d = IDLE;
            end
          end else begin
            stop_cnt_d = stop_cnt_q + 2'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (pop) begin
      shift_d = fifo_mem_q[rd_ptr_q];
`ifdef UART_TX_PARITY_EN
      parity_d = even_parity(fifo_mem_q[rd_ptr_q]);
`endif
    end

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);

    // Line level is registered from the state being entered, so it appears
    // on the cycle after the transition edge.
    case (state_d)
      START:   tx_serial_d = 1'b0;
      DATA:    tx_serial_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_serial_d = parity_d;
`endif
      default: tx_serial_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      bit_idx_q   <= '0;
      stop_cnt_q  <= '0;
      tx_serial_q <= 1'b1;
      tx_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      bit_idx_q   <= bit_idx_d;
      stop_cnt_q  <= stop_cnt_d;
      tx_serial_q <= tx_serial_d;
      tx_done_q   <= tx_done_d;
    end
  end

  // Datapath storage carries no reset; occupancy and pointers qualify it.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
`ifdef UART_TX_PARITY_EN
    parity_q <= parity_d;
`endif
    if (push) fifo_mem_q[wr_ptr_q] <= data_in;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo: two instances (STOP_BITS = 1 and 2) share
// stimulus and are compared every cycle against a frame-position reference
// model built from a byte queue.
module tb_uart_tx_fifo;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef UART_TX_PARITY_EN
  localparam int          PBITS    = 1;
  localparam logic [7:0]  DIR_BYTE = 8'h07;
  localparam logic [31:0] EXP_SEQ  = 32'b01110000011;
`else
  localparam int          PBITS    = 0;
  localparam logic [7:0]  DIR_BYTE = 8'hA5;
  localparam logic [31:0] EXP_SEQ  = 32'b0101001011;
`endif
  localparam int NBITS = 10 + PBITS;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          baud_tick = 1'b0;
  logic          tx_valid = 1'b0;
  logic [7:0]    data_in = 8'h00;
  logic [1:0]    ready, serial, busy, done;
  logic [CW-1:0] cnt0, cnt1;

  always #5 clk = ~clk;

  uart_tx_fifo #(.FIFO_DEPTH(DEPTH), .STOP_BITS(1)) u_dut1 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .data_in(data_in),
    .tx_valid(tx_valid), .tx_ready(ready[0]), .tx_serial(serial[0]),
    .tx_busy(busy[0]), .tx_done(done[0]), .fifo_count(cnt0)
  );

  uart_tx_fifo #(.FIFO_DEPTH(DEPTH), .STOP_BITS(2)) u_dut2 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .data_in(data_in),
    .tx_valid(tx_valid), .tx_ready(ready[1]), .tx_serial(serial[1]),
    .tx_busy(busy[1]), .tx_done(done[1]), .fifo_count(cnt1)
  );

  // Reference model: a byte queue per instance plus the bit position inside
  // the frame currently on the line (-1 = idle).
  logic [7:0] mbuf [2][16];
  int         mhead [2];
  int         msize [2];
  int         mpos  [2];
  logic [7:0] mcur  [2];
  logic       mdone [2];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int flen(input int i);
    return 9 + PBITS + ((i == 0) ? 1 : 2);
  endfunction

  function automatic logic exp_bit(input int i);
    if (mpos[i] < 0)  return 1'b1;
    if (mpos[i] == 0) return 1'b0;
    if (mpos[i] <= 8) return mcur[i][mpos[i]-1];
    if (PBITS == 1 && mpos[i] == 9) return ^mcur[i];
    return 1'b1;
  endfunction

  task automatic model_pop(input int i);
    mcur[i]  = mbuf[i][mhead[i]];
    mhead[i] = (mhead[i] + 1) % 16;
    msize[i] = msize[i] - 1;
    mpos[i]  = 0;
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        msize[i] = 0; mhead[i] = 0; mpos[i] = -1; mdone[i] = 1'b0;
      end else begin
        logic push_ok;
        push_ok  = tx_valid && (msize[i] != DEPTH);
        mdone[i] = 1'b0;
        if (baud_tick) begin
          if (mpos[i] < 0) begin
            if (msize[i] > 0) model_pop(i);
          end else if (mpos[i] == flen(i) - 1) begin
            mdone[i] = 1'b1;
            if (msize[i] > 0) model_pop(i);
            else mpos[i] = -1;
          end else begin
            mpos[i] = mpos[i] + 1;
          end
        end
        if (push_ok) begin
          mbuf[i][(mhead[i] + msize[i]) % 16] = data_in;
          msize[i] = msize[i] + 1;
        end
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("tx_serial[%0d]", i), 32'(serial[i]), 32'(exp_bit(i)));
      chk($sformatf("tx_busy[%0d]", i), 32'(busy[i]), 32'(mpos[i] >= 0));
      chk($sformatf("tx_done[%0d]", i), 32'(done[i]), 32'(mdone[i]));
      chk($sformatf("fifo_count[%0d]", i), (i == 0) ? 32'(cnt0) : 32'(cnt1), 32'(msize[i]));
      chk($sformatf("tx_ready[%0d]", i), 32'(ready[i]), 32'(msize[i] != DEPTH));
    end
  endtask

  task automatic cycle(input logic r, input logic t, input logic v, input logic [7:0] d);
    rst = r; baud_tick = t; tx_valid = v; data_in = d;
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic drain(input int period);
    int n;
    n = 0;
    while ((mpos[0] >= 0 || mpos[1] >= 0 || msize[0] != 0 || msize[1] != 0) && n < 3000) begin
      cycle(1'b0, (n % period) == period - 1, 1'b0, 8'h00);
      n++;
    end
    chk("drain_timeout", 32'(n >= 3000), 32'(0));
  endtask

  initial begin
    logic [31:0] seq;
    int ndone, nlow, n, tick_div;

    for (int i = 0; i < 2; i++) begin
      msize[i] = 0; mhead[i] = 0; mpos[i] = -1; mdone[i] = 1'b0; mcur[i] = 8'h00;
    end

    // Reset, then idle ticks with an empty FIFO.
    cycle(1'b1, 1'b0, 1'b0, 8'h00);
    cycle(1'b1, 1'b1, 1'b0, 8'h00);
    for (int k = 0; k < 5; k++) cycle(1'b0, 1'b1, 1'b0, 8'h00);

    // Single directed frame: capture the line after each tick.
    cycle(1'b0, 1'b0, 1'b1, DIR_BYTE);
    seq = '0;
    ndone = 0;
    for (int k = 0; k < NBITS; k++) begin
      cycle(1'b0, 1'b1, 1'b0, 8'h00);
      seq = {seq[30:0], serial[0]};
      ndone += int'(done[0]);
      cycle(1'b0, 1'b0, 1'b0, 8'h00);
    end
    chk("frame_bits", seq, EXP_SEQ);
    cycle(1'b0, 1'b1, 1'b0, 8'h00);
    ndone += int'(done[0]);
    chk("frame_done_cnt", 32'(ndone), 32'(1));
    chk("frame_end_busy", 32'(busy[0]), 32'(0));
    chk("frame_end_line", 32'(serial[0]), 32'(1));
    drain(2);

    // Back-to-back frames with a tick every cycle.
    cycle(1'b0, 1'b0, 1'b1, 8'h55);
    cycle(1'b0, 1'b0, 1'b1, 8'h0F);
    ndone = 0; nlow = 0;
    for (int k = 0; k < 2 * NBITS + 1; k++) begin
      cycle(1'b0, 1'b1, 1'b0, 8'h00);
      ndone += int'(done[0]);
      if (k < 2 * NBITS && !busy[0]) nlow++;
    end
    chk("b2b_done_cnt", 32'(ndone), 32'(2));
    chk("b2b_busy_low", 32'(nlow), 32'(0));
    drain(1);

    // Full FIFO with ticks held low: fifth byte refused.
    for (int k = 0; k < 5; k++) cycle(1'b0, 1'b0, 1'b1, 8'($urandom));
    chk("full_count", 32'(cnt0), 32'(DEPTH));
    chk("full_ready", 32'(ready[0]), 32'(0));
    drain(3);

    // Reset during data bit 3 with two bytes still queued.
    for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 1'b1, 8'($urandom));
    n = 0;
    while (mpos[0] != 4 && n < 200) begin
      cycle(1'b0, (n % 2) == 1, 1'b0, 8'h00);
      n++;
    end
    chk("mid_reset_reach", 32'(msize[0] == 2 && mpos[0] == 4), 32'(1));
    cycle(1'b1, 1'b0, 1'b1, 8'hC3);
    chk("mid_reset_line", 32'(serial[0]), 32'(1));
    chk("mid_reset_count", 32'(cnt0), 32'(0));
    chk("mid_reset_busy", 32'(busy[0]), 32'(0));
    chk("mid_reset_done", 32'(done[0]), 32'(0));
    for (int k = 0; k < 6; k++) cycle(1'b0, 1'b1, 1'b0, 8'h00);

    // Randomized traffic with varying tick rates and occasional resets.
    tick_div = 3;
    for (int k = 0; k < 4000; k++) begin
      if (k % 500 == 0) tick_div = int'($urandom_range(1, 6));
      cycle($urandom_range(0, 599) == 0,
            $urandom_range(0, tick_div - 1) == 0,
            $urandom_range(0, 1) == 1,
            8'($urandom));
    end
    drain(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
